// File: rtl/controller_gen2.sv
// Instruction-sequencing controller for the 8-phase RISC CPU.
// Optional macro CTRL_READY_EN: stretched fetch phases also wait for mem_ready.
module controller_gen2 #(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                is_zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e,
    output logic [3:0]          state,
    output logic                illegal
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;

    logic [2:0] op_w;
    logic       hlt_w, skz_w, jmp_w, sto_w, aluop_w, ill_w, ready_w;

    assign op_w    = opcode[2:0];
    assign hlt_w   = (op_w == 3'd0);
    assign skz_w   = (op_w == 3'd1);
    assign sto_w   = (op_w == 3'd6);
    assign jmp_w   = (op_w == 3'd7);
    assign aluop_w = (op_w == 3'd2) || (op_w == 3'd3) || (op_w == 3'd4) || (op_w == 3'd5);

    generate
        if (OPCODE_W > 3) begin : g_ill
            assign ill_w = |opcode[OPCODE_W-1:3];
        end else begin : g_no_ill
            assign ill_w = 1'b0;
        end
    endgenerate

`ifdef CTRL_READY_EN
    assign ready_w = mem_ready;
`else
    // mem_ready has no effect in this build; OR-ing keeps the port referenced.
    assign ready_w = mem_ready | 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INST_ADDR;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            INST_ADDR: begin
                state_d = INST_FETCH;
                cnt_d   = WAIT_INIT;
            end
            INST_FETCH: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (ready_w) begin
                    state_d = INST_LOAD;
                end
            end
            INST_LOAD: state_d = IDLE;
            IDLE:      state_d = OP_ADDR;
            OP_ADDR: begin
                if (hlt_w || ill_w) begin
                    state_d   = HALTED;
                    illegal_d = ill_w;
                end else begin
                    state_d = OP_FETCH;
                    cnt_d   = aluop_w ? WAIT_INIT : '0;
                end
            end
            // Only ALU-type instructions read memory here, so only they stretch.
            OP_FETCH: begin
                if (!aluop_w) begin
                    state_d = ALU_OP;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (ready_w) begin
                    state_d = ALU_OP;
                end
            end
            ALU_OP: state_d = STORE;
            STORE:  state_d = INST_ADDR;
            HALTED: begin
                if (resume) begin
                    state_d   = INST_ADDR;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = INST_ADDR;
        endcase
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        case (state_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = hlt_w | ill_w;
            end
            OP_FETCH: rd = aluop_w;
            ALU_OP: begin
                rd     = aluop_w;
                inc_pc = skz_w & is_zero;
                ld_pc  = jmp_w;
                data_e = sto_w;
            end
            STORE: begin
                rd     = aluop_w;
                ld_ac  = aluop_w;
                ld_pc  = jmp_w;
                wr     = sto_w;
                data_e = sto_w;
            end
            HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_controller_gen2.sv
// Directed self-checking bench for controller_gen2 (two parameterisations).
module tb_controller_gen2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a_opcode;
    logic [2:0] b_opcode;
    logic       is_zero, resume, mem_ready;

    logic a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e, a_illegal;
    logic b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e, b_illegal;
    logic [3:0] a_state, b_state;
    logic [8:0] a_strb, b_strb;

    int vectors = 0;
    int errors  = 0;

    // Strobe order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
    assign a_strb = {a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e};
    assign b_strb = {b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e};

    controller_gen2 #(.OPCODE_W(4), .MEM_WAIT(0)) dut_a (
        .clk(clk), .rst(rst), .opcode(a_opcode), .is_zero(is_zero),
        .mem_ready(mem_ready), .resume(resume),
        .sel(a_sel), .rd(a_rd), .ld_ir(a_ld_ir), .halt(a_halt), .inc_pc(a_inc_pc),
        .ld_ac(a_ld_ac), .ld_pc(a_ld_pc), .wr(a_wr), .data_e(a_data_e),
        .state(a_state), .illegal(a_illegal)
    );

    controller_gen2 #(.OPCODE_W(3), .MEM_WAIT(2)) dut_b (
        .clk(clk), .rst(rst), .opcode(b_opcode), .is_zero(is_zero),
        .mem_ready(mem_ready), .resume(resume),
        .sel(b_sel), .rd(b_rd), .ld_ir(b_ld_ir), .halt(b_halt), .inc_pc(b_inc_pc),
        .ld_ac(b_ld_ac), .ld_pc(b_ld_pc), .wr(b_wr), .data_e(b_data_e),
        .state(b_state), .illegal(b_illegal)
    );

    always #5 clk = ~clk;

    task automatic reset_all;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        a_opcode = 4'b0010;
        b_opcode = 3'b101;
        is_zero  = 1'b0;
        resume   = 1'b0;
        reset_all();
        repeat (6) @(negedge clk);
        vectors++;
        if (a_state !== 4'd6) begin
            errors++; $display("FAIL reset_pre_state got %0d want 6", a_state);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (a_state !== 4'd0) begin
            errors++; $display("FAIL reset_state got %0d want 0", a_state);
        end
        vectors++;
        if (a_strb !== 9'h100) begin
            errors++; $display("FAIL reset_strobes got %h want 100", a_strb);
        end
        vectors++;
        if (a_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal got %b want 0", a_illegal);
        end
        vectors++;
        if (b_state !== 4'd0 || b_strb !== 9'h100) begin
            errors++; $display("FAIL reset_b got state %0d strb %h want 0/100", b_state, b_strb);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (a_state !== 4'd1 || b_state !== 4'd1) begin
            errors++; $display("FAIL reset_release got %0d/%0d want 1/1", a_state, b_state);
        end
    endtask

    task automatic test_instr(input string name, input logic [3:0] opc, input logic z,
                              input logic r, input logic [8:0] e4, input logic [8:0] e5,
                              input logic [8:0] e6, input logic [8:0] e7);
        logic [8:0] exp_strb [8];
        exp_strb = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, e4, e5, e6, e7};
        a_opcode = opc;
        is_zero  = z;
        resume   = r;
        reset_all();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (a_state !== 4'(i) || a_strb !== exp_strb[i]) begin
                errors++;
                $display("FAIL %s_s%0d got state %0d strb %h want state %0d strb %h",
                         name, i, a_state, a_strb, i, exp_strb[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (a_state !== 4'd0) begin
            errors++; $display("FAIL %s_wrap got %0d want 0", name, a_state);
        end
        resume = 1'b0;
    endtask

    task automatic test_halt;
        a_opcode = 4'b0000;
        resume   = 1'b0;
        reset_all();
        repeat (4) @(negedge clk);
        vectors++;
        if (a_state !== 4'd4 || a_strb !== 9'h030) begin
            errors++; $display("FAIL halt_opaddr got %0d/%h want 4/030", a_state, a_strb);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (a_state !== 4'd8 || a_strb !== 9'h020 || a_illegal !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold%0d got %0d/%h/%b want 8/020/0", i, a_state, a_strb, a_illegal);
            end
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        vectors++;
        if (a_state !== 4'd0 || a_strb !== 9'h100) begin
            errors++; $display("FAIL halt_resume got %0d/%h want 0/100", a_state, a_strb);
        end
        @(negedge clk);
        vectors++;
        if (a_state !== 4'd1) begin
            errors++; $display("FAIL halt_after_resume got %0d want 1", a_state);
        end
    endtask

    task automatic test_illegal;
        a_opcode = 4'b1010;
        resume   = 1'b0;
        reset_all();
        repeat (4) @(negedge clk);
        vectors++;
        if (a_state !== 4'd4 || a_strb !== 9'h030 || a_illegal !== 1'b0) begin
            errors++; $display("FAIL ill_opaddr got %0d/%h/%b want 4/030/0", a_state, a_strb, a_illegal);
        end
        @(negedge clk);
        vectors++;
        if (a_state !== 4'd8 || a_illegal !== 1'b1 || a_strb !== 9'h020) begin
            errors++; $display("FAIL ill_trap got %0d/%b/%h want 8/1/020", a_state, a_illegal, a_strb);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (a_illegal !== 1'b1) begin
            errors++; $display("FAIL ill_sticky got %b want 1", a_illegal);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        vectors++;
        if (a_state !== 4'd0 || a_illegal !== 1'b0) begin
            errors++; $display("FAIL ill_resume got %0d/%b want 0/0", a_state, a_illegal);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (a_state !== 4'd8 || a_illegal !== 1'b1) begin
            errors++; $display("FAIL ill_retrap got %0d/%b want 8/1", a_state, a_illegal);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (a_state !== 4'd0 || a_illegal !== 1'b0 || a_strb !== 9'h100) begin
            errors++; $display("FAIL ill_reset got %0d/%b/%h want 0/0/100", a_state, a_illegal, a_strb);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_wait_lda;
        int exp_seq [12];
        exp_seq  = '{0, 1, 1, 1, 2, 3, 4, 5, 5, 5, 6, 7};
        b_opcode = 3'b101;
        reset_all();
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (b_state !== 4'(exp_seq[i])) begin
                errors++; $display("FAIL wait_lda_c%0d got %0d want %0d", i, b_state, exp_seq[i]);
            end
            if (exp_seq[i] == 1 || exp_seq[i] == 5) begin
                vectors++;
                if (b_strb !== ((exp_seq[i] == 1) ? 9'h180 : 9'h080)) begin
                    errors++; $display("FAIL wait_lda_strb_c%0d got %h", i, b_strb);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (b_state !== 4'd0) begin
            errors++; $display("FAIL wait_lda_wrap got %0d want 0", b_state);
        end
    endtask

    task automatic test_wait_sto;
        int exp_seq [10];
        exp_seq  = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7};
        b_opcode = 3'b110;
        reset_all();
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (b_state !== 4'(exp_seq[i])) begin
                errors++; $display("FAIL wait_sto_c%0d got %0d want %0d", i, b_state, exp_seq[i]);
            end
            @(negedge clk);
        end
        vectors++;
        if (b_state !== 4'd0) begin
            errors++; $display("FAIL wait_sto_wrap got %0d want 0", b_state);
        end
    endtask

`ifdef CTRL_READY_EN
    task automatic test_ready;
        b_opcode  = 3'b101;
        mem_ready = 1'b0;
        reset_all();
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            vectors++;
            if (b_state !== 4'd1 || b_strb !== 9'h180) begin
                errors++; $display("FAIL ready_c%0d got %0d/%h want 1/180", k, b_state, b_strb);
            end
            mem_ready = (k == 7);
            @(negedge clk);
        end
        vectors++;
        if (b_state !== 4'd2) begin
            errors++; $display("FAIL ready_exit got %0d want 2", b_state);
        end
    endtask
`endif

    initial begin
`ifdef CTRL_READY_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;
`endif
        rst      = 1'b0;
        resume   = 1'b0;
        is_zero  = 1'b0;
        a_opcode = '0;
        b_opcode = '0;
        test_reset();
        test_instr("add",    4'b0010, 1'b0, 1'b1, 9'h010, 9'h080, 9'h080, 9'h088);
        test_instr("xor",    4'b0100, 1'b1, 1'b0, 9'h010, 9'h080, 9'h080, 9'h088);
        test_instr("skz_z1", 4'b0001, 1'b1, 1'b0, 9'h010, 9'h000, 9'h010, 9'h000);
        test_instr("skz_z0", 4'b0001, 1'b0, 1'b0, 9'h010, 9'h000, 9'h000, 9'h000);
        test_instr("jmp",    4'b0111, 1'b0, 1'b0, 9'h010, 9'h000, 9'h004, 9'h004);
        test_instr("sto",    4'b0110, 1'b0, 1'b0, 9'h010, 9'h000, 9'h001, 9'h003);
        test_halt();
        test_illegal();
        test_wait_lda();
        test_wait_sto();
`ifdef CTRL_READY_EN
        test_ready();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/controller_gen2.md
# controller_gen2

Second-generation instruction-sequencing controller for the 8-phase RISC CPU. It drives the datapath strobes (`sel`, `rd`, `ld_ir`, `halt`, `inc_pc`, `ld_ac`, `ld_pc`, `wr`, `data_e`) from the current phase, the IR opcode and the accumulator zero flag. Compared with the first-generation controller it adds four things: a parametrised opcode width with illegal-opcode trapping, configurable memory wait states, a sticky HALTED state with resume, and an exported phase code. It sits between the instruction register and the PC, accumulator, ALU and memory-bus enables.

## Interface
- `OPCODE_W`, default 3: opcode width, ≥3. Bits [2:0] select the instruction; any set bit above bit 2 makes the opcode illegal.
- `MEM_WAIT`, default 0: extra stall cycles, 0..7, inserted in each read-fetch phase.

- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `opcode` input, `OPCODE_W` bits: IR opcode field.
- `is_zero` input, 1 bit: accumulator is zero.
- `mem_ready` input, 1 bit: memory ready. Used only with `CTRL_READY_EN`.
- `resume` input, 1 bit: leave the HALTED state.
- `sel`, `rd`, `ld_ir`, `halt`, `inc_pc`, `ld_ac`, `ld_pc`, `wr`, `data_e` output, 1 bit each: datapath strobes.
- `state` output, 4 bits: phase code. 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE, 8 HALTED.
- `illegal` output, 1 bit: sticky illegal-opcode flag.

## Operation
- Instruction decode uses `opcode[2:0]`: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP is true for ADD, AND, XOR and LDA.
- ILL is true when `opcode[OPCODE_W-1:3]` is not zero. ILL is treated as HLT. When `OPCODE_W`=3, ILL is never true.
- Strobes are combinational from the registered `state`, the decoded opcode and `is_zero`. Any strobe not listed for a phase is 0.
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc`=1; `halt`=HLT|ILL.
  - OP_FETCH: `rd`=ALUOP.
  - ALU_OP: `rd`=ALUOP; `inc_pc`=SKZ&`is_zero`; `ld_pc`=JMP; `data_e`=STO.
  - STORE: `rd`=ALUOP; `ld_ac`=ALUOP; `ld_pc`=JMP; `wr`=STO; `data_e`=STO.
  - HALTED: `halt` only.
- Phase sequence is 0→1→…→7→0.
  - Exception: from OP_ADDR with HLT|ILL, the next state is HALTED.
  - On that same edge, `illegal` is set if ILL is true.
- HALTED holds until `resume`=1 is sampled. The next state is then INST_ADDR and `illegal` clears. `resume` is ignored in every other state.
- Wait stretch: INST_FETCH, and OP_FETCH when ALUOP is true, each last 1+`MEM_WAIT` cycles.
  - A 3-bit counter loads `MEM_WAIT` on entry to the phase and decrements each cycle.
  - The phase exits when the counter is 0.
  - Strobes stay constant for the whole stretch.
- Resume continues at the next instruction, because the PC was already incremented in OP_ADDR.

## Timing
- On reset assertion, asynchronously:
  - `state`=0 and the wait counter is 0.
  - `illegal`=0.
  - Outputs: `sel`=1, all other strobes 0.
- Reset mid-instruction (including during HALTED or a wait stretch) aborts immediately to the same values. The first INST_ADDR cycle starts on the first rising edge after deassertion.
- With `MEM_WAIT`=0, one instruction takes exactly 8 cycles.
- Per-instruction cycle count = 8 + `MEM_WAIT` + (ALUOP ? `MEM_WAIT` : 0).
- HLT/ILL: `halt` is high in OP_ADDR, then continuously from the first HALTED cycle. HALTED exits 1 cycle after `resume` is sampled high.
- `opcode` and `is_zero` must be stable from IDLE through STORE. The IR is loaded in INST_LOAD/IDLE.
- `mem_ready` is sampled only in the final (counter=0) cycle of a stretched phase.

## Configuration
- `CTRL_READY_EN`:
  - When defined, after the `MEM_WAIT` count expires, INST_FETCH and ALUOP OP_FETCH additionally hold until `mem_ready`=1 is sampled. Strobes are held throughout.
  - When not defined, `mem_ready` is ignored and the stretch is exactly `MEM_WAIT` cycles.

## Test plan
- Reset: hold `rst`=1 mid-ALU_OP → immediately `state`=0, `sel`=1, all other strobes 0, `illegal`=0. The first edge after release gives `state`=1.
- `MEM_WAIT`=0, opcode=3'b010 (ADD) → 8-cycle loop. `rd`=1 in states 1,2,3,5,6,7 and 0 in states 0 and 4. `ld_ac`=1 only in state 7. `inc_pc`=1 only in state 4.
- SKZ with `is_zero`=1 → `inc_pc`=1 in states 4 and 6. SKZ with `is_zero`=0 → `inc_pc`=1 in state 4 only. JMP → `ld_pc`=1 in states 6 and 7. STO → `data_e`=1 in states 6 and 7, `wr`=1 in state 7 only.
- HLT → `halt`=1 in state 4, then `state`=8 held for 20 cycles with `halt`=1. A 1-cycle `resume` pulse gives `state`=0 on the next edge.
- `OPCODE_W`=4, opcode=4'b1010 → `illegal`=1 with `state`=8. After `resume`, `illegal`=0 and `state`=0.
- `MEM_WAIT`=2, opcode=3'b101 (LDA) → states 1 and 5 each last 3 cycles, loop length 12 cycles. With `CTRL_READY_EN` and `mem_ready` held low 4 extra cycles → state 1 lasts 7 cycles with `sel`=`rd`=1 throughout.
